// File: rtl/ring_interlock_arbiter.sv
// Ring interlock arbiter: grants one shared resource to at most one of
// N_STATIONS ring stations. Priority rotates round-robin past each winner.
// A dead-time guard separates owners, and an owner that holds too long is
// revoked.

// Per-station release qualifier. Only the station that currently holds the
// grant can release it. It releases by pulsing done or by dropping its
// request.
module ring_interlock_station (
   input  logic grant,
   input  logic req,
   input  logic done,
   output logic rel
);
   assign rel = grant & (done | ~req);
endmodule

module ring_interlock_arbiter #(
   parameter  int N_STATIONS   = 8,
   parameter  int GUARD_CYCLES = 2,
   parameter  int MAX_HOLD     = 255,
   parameter  int CNT_W        = 8,
   localparam int IDX_W        = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_STATIONS-1:0] i_req,
   input  logic [N_STATIONS-1:0] i_done,
   output logic [N_STATIONS-1:0] o_grant,
   output logic [IDX_W-1:0]      o_owner,
   output logic                  o_busy,
   output logic                  o_timeout,
   output logic [IDX_W-1:0]      o_timeout_id
);

   typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   state_t                  state;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        winner;
   logic [IDX_W-1:0]        cand;
   logic [IDX_W-1:0]        ptr_next;
   logic                    found;
   logic [N_STATIONS-1:0]   win_onehot;
   logic [N_STATIONS-1:0]   rel_vec;
   logic                    rel;
   logic                    hold_expired;
   logic [CNT_W-1:0]        hold_cnt;
   logic [CNT_W-1:0]        guard_cnt;

   // Each station checks its own grant bit. The grant is one-hot, so the OR
   // of the per-station results is the owner's release.
   ring_interlock_station u_station [N_STATIONS-1:0] (
      .grant (o_grant),
      .req   (i_req),
      .done  (i_done),
      .rel   (rel_vec)
   );

   assign rel          = |rel_vec;
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   // Rotating search. The winner is the first requester at or above the
   // pointer, wrapping from the top station back to station 0.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < N_STATIONS; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N_STATIONS);
         if (!found && i_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // One-hot decode of the winner and the pointer value just past it.
   always_comb begin
      win_onehot         = '0;
      win_onehot[winner] = 1'b1;
      ptr_next           = IDX_W'((int'(winner) + 1) % N_STATIONS);
   end

   // Arbiter FSM. All outputs are registered and updated together with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         o_grant      <= '0;
         o_owner      <= '0;
         o_busy       <= 1'b0;
         o_timeout    <= 1'b0;
         o_timeout_id <= '0;
         ptr          <= '0;
         hold_cnt     <= '0;
         guard_cnt    <= '0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state    <= GRANT;
                  o_grant  <= win_onehot;
                  o_owner  <= winner;
                  o_busy   <= 1'b1;
                  ptr      <= ptr_next;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               // A release that arrives in the same cycle as expiry wins,
               // so no timeout is flagged.
               if (rel) begin
                  state     <= GUARD;
                  o_grant   <= '0;
                  guard_cnt <= GUARD_LOAD;
               end else if (hold_expired) begin
                  state        <= GUARD;
                  o_grant      <= '0;
                  guard_cnt    <= GUARD_LOAD;
                  o_timeout    <= 1'b1;
                  o_timeout_id <= o_owner;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GUARD: begin
               // A load of 0 or 1 both give a single guard cycle.
               if (guard_cnt <= CNT_W'(1)) begin
                  state     <= IDLE;
                  o_busy    <= 1'b0;
                  guard_cnt <= '0;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               o_grant <= '0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ring_interlock_arbiter.md
Name: ring_interlock_arbiter

Overview:
Sequential arbiter for the eight-station ring interlock (stations A..H, bit 0 = A ... bit 7 = H).
- Grants the shared interlocked resource to at most one station at a time.
- Rotates priority round-robin.
- Enforces a dead-time guard between owners.
- Revokes ownership on hold timeout.
- Its one-hot grant vector drives the per-station interlock enables and feedback lines.

Parameters:
N_STATIONS, 8, number of ring stations; width of request/grant vectors.
GUARD_CYCLES, 2, dead-time cycles with all grants low after each release or revoke; 0 allowed.
MAX_HOLD, 255, maximum cycles one owner may hold the grant; 0 disables the timeout.
CNT_W, 8, width of the hold and guard counters; must hold max(MAX_HOLD, GUARD_CYCLES).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
i_req  in  N_STATIONS  per-station request level; held high while the station wants or holds the resource.
i_done  in  N_STATIONS  per-station release pulse; only the owner's bit is honoured.
o_grant  out  N_STATIONS  registered grant vector, one-hot or zero.
o_owner  out  3  index of the current or last owner.
o_busy  out  1  high in GRANT and GUARD.
o_timeout  out  1  one-cycle pulse when the owner is revoked by timeout.
o_timeout_id  out  3  index of the revoked station; valid while o_timeout is high.

Behaviour:
- Reset (rst sampled high at a clk edge), next cycle:
  - state = IDLE
  - o_grant = 0, o_owner = 0, o_busy = 0, o_timeout = 0, o_timeout_id = 0
  - priority pointer = 0, so A is highest priority
  - both counters = 0
  - rst in any state aborts immediately; an active grant drops at that edge.
- IDLE:
  - If i_req != 0, select the first set bit searching upward from the pointer, wrapping H->A.
  - Next cycle: state = GRANT, o_grant = one-hot(winner), o_owner = winner, pointer = winner+1 mod 8, hold counter = 0.
  - Latency from a request sampled in IDLE to grant high is 1 cycle.
- GRANT:
  - Each cycle, release if i_done[owner] is high OR i_req[owner] is low.
  - On release: the next cycle has o_grant = 0 and enters GUARD.
  - Otherwise the hold counter increments.
  - If MAX_HOLD != 0 and the hold counter reaches MAX_HOLD-1 with no release, the next cycle has o_grant = 0, o_timeout = 1, o_timeout_id = owner, and enters GUARD.
  - If release and timeout coincide, release wins and o_timeout stays 0.
  - i_done bits from non-owners are ignored.
  - Requests from other stations never preempt the owner.
  - The owner holds the grant for at most MAX_HOLD cycles.
- GUARD:
  - o_grant = 0 and o_busy = 1.
  - The guard counter loads GUARD_CYCLES on entry, decrements each cycle, and moves to IDLE when it reaches 0.
  - With GUARD_CYCLES = 0, GUARD lasts 1 cycle.
  - Minimum all-low gap between two grants = max(GUARD_CYCLES,1) + 1 cycles (GUARD + IDLE).
  - Requests arriving during GUARD wait; they are not latched and must be held.
- Pointer:
  - Advances past each winner, including a timed-out winner.
  - A station that re-requests immediately after release therefore ranks lowest.
- Invariants:
  - popcount(o_grant) <= 1 every cycle.
  - o_grant is nonzero only in GRANT.
  - o_owner is unchanged outside IDLE->GRANT transitions.
- o_timeout is high for exactly one cycle per revoke.

Test Plan:
- Reset then i_req = 8'b0000_0001 held for 5 cycles, then dropped -> o_grant = 0x01 one cycle after req and held 5 cycles; o_grant = 0 for 3 cycles (GUARD_CYCLES = 2, plus IDLE); o_busy falls when IDLE is entered.
- i_req = 0xFF held, each owner pulses i_done 2 cycles after grant -> grant order A,B,C,...,H,A; every handover shows a 3-cycle all-zero gap; o_grant is never multi-hot.
- Owner C (0x04) holds with no i_done, MAX_HOLD = 255 -> grant high exactly 255 cycles; next cycle o_timeout = 1 with o_timeout_id = 2; the next grant goes to the next requester above C.
- Owner B while i_done = 0x10 (E, not owner) pulses -> ignored, grant unchanged; then B deasserts i_req -> release, GUARD entered.
- rst asserted mid-GRANT with owner F -> o_grant = 0 next cycle; pointer = 0; with i_req = 0xA0 after reset, grant goes to F (0x20) first.
- Release and timeout on the same cycle, at hold count MAX_HOLD-1 -> o_timeout stays 0; normal GUARD entry.
